// File: rtl/sterowanie_odliczaniem_pkg.sv
// Shared definitions for the countdown control stage: FSM state encoding,
// BCD limits, edit-button bit positions and a decimal-to-BCD helper.
package sterowanie_odliczaniem_pkg;

  typedef enum logic [1:0] {
    USTAWIANIE = 2'd0,
    ODLICZANIE = 2'd1,
    PAUZA      = 2'd2,
    ALARM      = 2'd3
  } stan_t;

  localparam logic [7:0] SEC_MAX = 8'h59;

  // Bit positions inside i_Przyciski_stan
  localparam int unsigned IS = 3;
  localparam int unsigned DS = 2;
  localparam int unsigned IM = 1;
  localparam int unsigned DM = 0;

  // Two-digit BCD code of a decimal value 0..99
  function automatic logic [7:0] na_bcd(input int unsigned v);
    return {4'(v / 10), 4'(v % 10)};
  endfunction

endpackage

// File: rtl/licznik_bcd_mod.sv
// Two-digit BCD up/down counter with a BCD upper limit MAX.
// Ports: i_CLK, i_RSTn (sync, active-low); i_Inc/i_Dec step the value,
// i_Zawijaj selects wrap (1) or saturate (0) at the limits, i_Zeruj loads 00
// and has priority. o_Wartosc is the registered value, o_Pozyczka_c flags that
// the value is 00 (a decrement would borrow), o_Zero_c flags value 00.
module licznik_bcd_mod #(
  parameter logic [7:0] MAX = 8'h59
) (
  input  logic       i_CLK,
  input  logic       i_RSTn,
  input  logic       i_Inc,
  input  logic       i_Dec,
  input  logic       i_Zawijaj,
  input  logic       i_Zeruj,
  output logic [7:0] o_Wartosc,
  output logic       o_Pozyczka_c,
  output logic       o_Zero_c
);

  logic [3:0] jedn;
  logic [3:0] dzies;
  logic [7:0] wartosc_d;

  assign jedn         = o_Wartosc[3:0];
  assign dzies        = o_Wartosc[7:4];
  assign o_Zero_c     = (o_Wartosc == 8'h00);
  assign o_Pozyczka_c = o_Zero_c;

  // Next value: digits roll 9->0 / 0->9 so no illegal BCD code is ever formed
  always_comb begin
    wartosc_d = o_Wartosc;
    if (i_Zeruj) begin
      wartosc_d = 8'h00;
    end else if (i_Inc) begin
      if (o_Wartosc == MAX)  wartosc_d = i_Zawijaj ? 8'h00 : MAX;
      else if (jedn == 4'd9) wartosc_d = {dzies + 4'd1, 4'd0};
      else                   wartosc_d = {dzies, jedn + 4'd1};
    end else if (i_Dec) begin
      if (o_Zero_c)          wartosc_d = i_Zawijaj ? MAX : 8'h00;
      else if (jedn == 4'd0) wartosc_d = {dzies - 4'd1, 4'd9};
      else                   wartosc_d = {dzies, jedn - 4'd1};
    end
  end

  always_ff @(posedge i_CLK) begin
    if (!i_RSTn) o_Wartosc <= 8'h00;
    else         o_Wartosc <= wartosc_d;
  end

endmodule

// File: rtl/sterowanie_odliczaniem.sv
// Countdown-timer control: BCD MM:SS setting with auto-repeat editing,
// 1 Hz countdown and the set/run/pause/alarm state machine.
// Ports: i_CLK, i_RSTn (sync, active-low); i_Przyciski_stan {IS,DS,IM,DM}
// levels, i_Przyciski_impuls edit press pulse, i_Przyciski_przytrzymanie edit
// hold flag, i_Odliczanie_impuls start/stop pulse, i_Odliczanie_przytrzymanie
// start/stop hold flag; o_Minuty/o_Sekundy BCD time, o_Stan FSM state,
// o_Alarm high in ALARM, o_Koniec_impuls one-cycle pulse on reaching 00:00.
module sterowanie_odliczaniem
  import sterowanie_odliczaniem_pkg::*;
#(
  parameter int unsigned CLK_HZ    = 100_000_000,
  parameter int unsigned REPEAT_HZ = 10,
  parameter int unsigned MAX_MIN   = 99
) (
  input  logic       i_CLK,
  input  logic       i_RSTn,
  input  logic [3:0] i_Przyciski_stan,
  input  logic       i_Przyciski_impuls,
  input  logic       i_Przyciski_przytrzymanie,
  input  logic       i_Odliczanie_impuls,
  input  logic       i_Odliczanie_przytrzymanie,
  output logic [7:0] o_Minuty,
  output logic [7:0] o_Sekundy,
  output logic [1:0] o_Stan,
  output logic       o_Alarm,
  output logic       o_Koniec_impuls
);

  localparam int unsigned REP_DIV = (CLK_HZ / REPEAT_HZ > 0) ? CLK_HZ / REPEAT_HZ : 1;
  localparam int unsigned TICK_W  = $clog2(CLK_HZ + 1);
  localparam int unsigned REP_W   = $clog2(REP_DIV + 1);
  localparam logic [7:0]  MIN_MAX = na_bcd(MAX_MIN);

  stan_t             stan_q, stan_d;
  logic [TICK_W-1:0] tick_q, tick_d;
  logic [REP_W-1:0]  rep_q, rep_d;
  logic              hold_q;
  logic              alarm_d, koniec_d;

  logic hold_edge, rep_step, edit_step, tick;
  logic sec_inc, sec_dec, sec_zero, min_inc, min_dec, min_zero;
  logic sec_zero_c, sec_pozyczka_c, min_zero_c, min_pozyczka_c, czas_zero;

  assign hold_edge = i_Odliczanie_przytrzymanie & ~hold_q;
  assign tick      = (tick_q == TICK_W'(CLK_HZ - 1));
  assign czas_zero = sec_zero_c & min_zero_c;
  assign o_Stan    = stan_q;

  licznik_bcd_mod #(.MAX(SEC_MAX)) u_sekundy (
    .i_CLK        (i_CLK),
    .i_RSTn       (i_RSTn),
    .i_Inc        (sec_inc),
    .i_Dec        (sec_dec),
    .i_Zawijaj    (1'b1),
    .i_Zeruj      (sec_zero),
    .o_Wartosc    (o_Sekundy),
    .o_Pozyczka_c (sec_pozyczka_c),
    .o_Zero_c     (sec_zero_c)
  );

  licznik_bcd_mod #(.MAX(MIN_MAX)) u_minuty (
    .i_CLK        (i_CLK),
    .i_RSTn       (i_RSTn),
    .i_Inc        (min_inc),
    .i_Dec        (min_dec),
    .i_Zawijaj    (1'b1),
    .i_Zeruj      (min_zero),
    .o_Wartosc    (o_Minuty),
    .o_Pozyczka_c (min_pozyczka_c),
    .o_Zero_c     (min_zero_c)
  );

  // State register and counters
  always_ff @(posedge i_CLK) begin
    if (!i_RSTn) begin
      stan_q          <= USTAWIANIE;
      tick_q          <= '0;
      rep_q           <= '0;
      hold_q          <= 1'b0;
      o_Alarm         <= 1'b0;
      o_Koniec_impuls <= 1'b0;
    end else begin
      stan_q          <= stan_d;
      tick_q          <= tick_d;
      rep_q           <= rep_d;
      hold_q          <= i_Odliczanie_przytrzymanie;
      o_Alarm         <= alarm_d;
      o_Koniec_impuls <= koniec_d;
    end
  end

  // Next state, counter updates and BCD counter controls
  always_comb begin
    stan_d    = stan_q;
    tick_d    = tick_q;
    rep_d     = '0;
    rep_step  = 1'b0;
    koniec_d  = 1'b0;
    sec_inc   = 1'b0;
    sec_dec   = 1'b0;
    sec_zero  = 1'b0;
    min_inc   = 1'b0;
    min_dec   = 1'b0;
    min_zero  = 1'b0;

    // Auto-repeat divider runs only while the edit hold flag is up
    if (i_Przyciski_przytrzymanie) begin
      if (rep_q == REP_W'(REP_DIV - 1)) rep_step = 1'b1;
      else                              rep_d    = rep_q + REP_W'(1);
    end
    edit_step = i_Przyciski_impuls | rep_step;

    if (hold_edge) begin
      stan_d   = USTAWIANIE;
      sec_zero = 1'b1;
      min_zero = 1'b1;
      tick_d   = '0;
    end else begin
      case (stan_q)
        USTAWIANIE: begin
          if (i_Odliczanie_impuls && !czas_zero) begin
            stan_d = ODLICZANIE;
            tick_d = '0;
          end else if (edit_step) begin
            if      (i_Przyciski_stan[IS]) sec_inc = 1'b1;
            else if (i_Przyciski_stan[DS]) sec_dec = 1'b1;
            else if (i_Przyciski_stan[IM]) min_inc = 1'b1;
            else if (i_Przyciski_stan[DM]) min_dec = 1'b1;
          end
        end
        ODLICZANIE: begin
          if (tick) begin
            tick_d  = '0;
            sec_dec = 1'b1;
            min_dec = sec_pozyczka_c;
            // Minutes cannot lend, so 00:01 is the last second
            if (min_pozyczka_c && o_Sekundy == 8'h01) begin
              stan_d   = ALARM;
              koniec_d = 1'b1;
            end else if (i_Odliczanie_impuls) begin
              stan_d = PAUZA;
            end
          end else begin
            tick_d = tick_q + TICK_W'(1);
            if (i_Odliczanie_impuls) stan_d = PAUZA;
          end
        end
        PAUZA: begin
          if (i_Odliczanie_impuls) stan_d = ODLICZANIE;
        end
        ALARM: begin
          if (i_Odliczanie_impuls || i_Przyciski_impuls) stan_d = USTAWIANIE;
        end
        default: stan_d = USTAWIANIE;
      endcase
    end

    alarm_d = (stan_d == ALARM);
  end

endmodule

// File: tb/tb_sterowanie_odliczaniem.sv
// Scoreboard bench for sterowanie_odliczaniem (CLK_HZ=100, REPEAT_HZ=10).
module tb_sterowanie_odliczaniem;

  localparam int CLK_HZ  = 100;
  localparam int REP_DIV = 10;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] p_stan = 4'b0;
  logic       p_imp = 1'b0, p_hold = 1'b0, o_imp = 1'b0, o_hold = 1'b0;
  logic [7:0] minuty, sekundy;
  logic [1:0] stan;
  logic       alarm, koniec;

  int checks = 0;
  int errors = 0;
  int cycle  = 0;
  bit mon_en = 1'b0;

  typedef struct { int cyc; logic [19:0] val; } ev_t;
  ev_t exp_q[$];

  sterowanie_odliczaniem #(.CLK_HZ(CLK_HZ), .REPEAT_HZ(10), .MAX_MIN(99)) dut (
    .i_CLK                      (clk),
    .i_RSTn                     (rst_n),
    .i_Przyciski_stan           (p_stan),
    .i_Przyciski_impuls         (p_imp),
    .i_Przyciski_przytrzymanie  (p_hold),
    .i_Odliczanie_impuls        (o_imp),
    .i_Odliczanie_przytrzymanie (o_hold),
    .o_Minuty                   (minuty),
    .o_Sekundy                  (sekundy),
    .o_Stan                     (stan),
    .o_Alarm                    (alarm),
    .o_Koniec_impuls            (koniec)
  );

  initial forever #5 clk = ~clk;

  function automatic logic [7:0] bcd(input int v);
    logic [3:0] t, u;
    t = 4'(v / 10);
    u = 4'(v % 10);
    return {t, u};
  endfunction

  // Reference model: time kept as plain integers, countdown via total seconds
  int  m_min = 0, m_sec = 0, m_st = 0, m_tick = 0, m_rep = 0;
  bit  m_hold_prev = 0, m_kon = 0;
  logic [19:0] m_last = '0;

  always @(posedge clk) begin
    bit edge_h, rstep, edit;
    int t;
    logic [19:0] e;
    cycle++;
    m_kon = 0;
    if (!rst_n) begin
      m_min = 0; m_sec = 0; m_st = 0; m_tick = 0; m_rep = 0; m_hold_prev = 0;
    end else begin
      edge_h = o_hold && !m_hold_prev;
      m_hold_prev = o_hold;
      rstep = 0;
      if (!p_hold) m_rep = 0;
      else begin
        m_rep++;
        if (m_rep == REP_DIV) begin m_rep = 0; rstep = 1; end
      end
      edit = p_imp || rstep;
      if (edge_h) begin
        m_st = 0; m_min = 0; m_sec = 0; m_tick = 0;
      end else begin
        case (m_st)
          0: if (o_imp && (m_min != 0 || m_sec != 0)) begin
               m_st = 1; m_tick = 0;
             end else if (edit) begin
               if      (p_stan[3]) m_sec = (m_sec + 1) % 60;
               else if (p_stan[2]) m_sec = (m_sec + 59) % 60;
               else if (p_stan[1]) m_min = (m_min + 1) % 100;
               else if (p_stan[0]) m_min = (m_min + 99) % 100;
             end
          1: begin
               m_tick++;
               if (m_tick == CLK_HZ) begin
                 m_tick = 0;
                 t = m_min * 60 + m_sec - 1;
                 m_min = t / 60;
                 m_sec = t % 60;
                 if (t == 0) begin m_st = 3; m_kon = 1; end
                 else if (o_imp) m_st = 2;
               end else if (o_imp) m_st = 2;
             end
          2: if (o_imp) m_st = 1;
          default: if (o_imp || p_imp) m_st = 0;
        endcase
      end
    end
    e = {bcd(m_min), bcd(m_sec), 2'(m_st), (m_st == 3), m_kon};
    if (e != m_last) exp_q.push_back('{cycle, e});
    m_last = e;
  end

  // Monitor: every change of the DUT output tuple must match the next expected event
  logic [19:0] prev_d = '0;
  always @(negedge clk) begin
    logic [19:0] d;
    ev_t ex;
    if (mon_en) begin
      d = {minuty, sekundy, stan, alarm, koniec};
      if (d !== prev_d) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL sb_unexpected cyc=%0d got %h", cycle, d);
        end else begin
          ex = exp_q.pop_front();
          if (ex.val !== d || ex.cyc != cycle) begin
            errors++;
            $display("FAIL sb_event got %h@%0d want %h@%0d", d, cycle, ex.val, ex.cyc);
          end
        end
        prev_d = d;
      end
    end
  end

  task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp_v);
    checks++;
    if (act !== exp_v) begin
      errors++;
      $display("FAIL %s got %h want %h", nm, act, exp_v);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic edit_pulse(input logic [3:0] s);
    p_stan = s; p_imp = 1'b1;
    cyc(1);
    p_imp = 1'b0; p_stan = 4'b0;
    cyc(1);
  endtask

  task automatic o_pulse();
    o_imp = 1'b1;
    cyc(1);
    o_imp = 1'b0;
  endtask

  task automatic do_reset(input int n);
    rst_n = 1'b0;
    cyc(n);
    rst_n = 1'b1;
  endtask

  task automatic set_time(input int m, input int s);
    do_reset(1);
    repeat (m) edit_pulse(4'b0010);
    repeat (s) edit_pulse(4'b1000);
  endtask

  initial begin
    cyc(3);
    rst_n = 1'b1;
    mon_en = 1'b1;
    chk("reset_min", minuty, 8'h00);
    chk("reset_stan", {6'b0, stan}, 8'h00);
    chk("reset_alarm", {7'b0, alarm}, 8'h00);

    // Editing with seconds wrap and no borrow
    repeat (3) edit_pulse(4'b1000);
    repeat (2) edit_pulse(4'b0010);
    chk("t1_min", minuty, 8'h02);
    chk("t1_sec", sekundy, 8'h03);
    repeat (4) edit_pulse(4'b0100);
    chk("t1_wrap_min", minuty, 8'h02);
    chk("t1_wrap_sec", sekundy, 8'h59);

    // Countdown cadence
    set_time(1, 1);
    o_pulse();
    cyc(99);
    chk("t2_before", sekundy, 8'h01);
    cyc(1);
    chk("t2_100_min", minuty, 8'h01);
    chk("t2_100_sec", sekundy, 8'h00);
    cyc(100);
    chk("t2_200_min", minuty, 8'h00);
    chk("t2_200_sec", sekundy, 8'h59);

    // Pause keeps the partial second
    set_time(0, 2);
    o_pulse();
    cyc(149);
    o_pulse();
    cyc(500);
    chk("t3_paused_sec", sekundy, 8'h01);
    chk("t3_paused_stan", {6'b0, stan}, 8'h02);
    o_pulse();
    cyc(49);
    chk("t3_49_sec", sekundy, 8'h01);
    cyc(1);
    chk("t3_end_sec", sekundy, 8'h00);
    chk("t3_koniec", {7'b0, koniec}, 8'h01);
    cyc(1);
    chk("t3_koniec_off", {7'b0, koniec}, 8'h00);
    chk("t3_alarm", {7'b0, alarm}, 8'h01);
    chk("t3_stan", {6'b0, stan}, 8'h03);

    // Reset in ALARM, then start attempt at 00:00
    do_reset(1);
    chk("t6_alarm", {7'b0, alarm}, 8'h00);
    chk("t6_stan", {6'b0, stan}, 8'h00);
    o_pulse();
    cyc(2);
    chk("t6_ignored", {6'b0, stan}, 8'h00);

    // Auto-repeat
    set_time(0, 58);
    p_stan = 4'b1000; p_hold = 1'b1;
    cyc(35);
    p_stan = 4'b0; p_hold = 1'b0;
    cyc(1);
    chk("t4_min", minuty, 8'h00);
    chk("t4_sec", sekundy, 8'h01);

    // Hold edge coincident with a tick
    set_time(5, 30);
    o_pulse();
    cyc(99);
    o_hold = 1'b1;
    cyc(1);
    chk("t5_min", minuty, 8'h00);
    chk("t5_sec", sekundy, 8'h00);
    chk("t5_stan", {6'b0, stan}, 8'h00);
    chk("t5_koniec", {7'b0, koniec}, 8'h00);
    cyc(3);
    o_hold = 1'b0;
    cyc(2);

    // Randomized traffic
    for (int i = 0; i < 300; i++) begin
      case ($urandom_range(0, 9))
        0, 1, 2: edit_pulse(4'($urandom_range(0, 15)));
        3, 4:    begin o_pulse(); cyc($urandom_range(0, 3)); end
        5, 6:    cyc($urandom_range(1, 150));
        7: begin
             p_stan = 4'($urandom_range(0, 15)); p_hold = 1'b1;
             cyc($urandom_range(1, 40));
             p_hold = 1'b0; p_stan = 4'b0;
           end
        8: begin
             o_hold = 1'b1;
             cyc($urandom_range(1, 5));
             o_hold = 1'b0;
             cyc(1);
           end
        default: if ($urandom_range(0, 3) == 0) do_reset(1); else set_time($urandom_range(0, 3), $urandom_range(0, 5));
      endcase
    end

    cyc(5);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL sb_drain got %0d pending want 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
